// File: rtl/sdp_pkg.sv
// Shared types and helpers for the sdp_pipe datapath.
// sat_add is only referenced when SDP_SAT_EN is defined.
package sdp_pkg;

  // Helpers operate on a fixed container width; callers pass their live width w.
  localparam int unsigned MAXW  = 32;
  localparam int unsigned MAXW2 = 2 * MAXW;

  typedef struct packed {
    logic v3;
    logic v2;
    logic v1;
  } stage_valid_t;

  // Sign-extend the low w bits of v to 2*MAXW bits.
  function automatic logic [MAXW2-1:0] sext2w(input logic [MAXW-1:0] v,
                                               input int unsigned   w);
    logic signed [MAXW-1:0] t;
    t = $signed(v << (MAXW - w)) >>> (MAXW - w);
    return MAXW2'(t);
  endfunction

  // Signed add of two w-bit operands, clamped to [-2^(w-1), 2^(w-1)-1].
  function automatic logic [MAXW-1:0] sat_add(input logic [MAXW-1:0] p,
                                               input logic [MAXW-1:0] q,
                                               input int unsigned   w);
    logic signed [MAXW2-1:0] s;
    logic signed [MAXW2-1:0] hi;
    logic signed [MAXW2-1:0] lo;
    s  = $signed(sext2w(p, w)) + $signed(sext2w(q, w));
    hi = $signed((MAXW2'(1) << (w - 1)) - MAXW2'(1));
    lo = -$signed(MAXW2'(1) << (w - 1));
    if (s > hi) return MAXW'(hi);
    if (s < lo) return MAXW'(lo);
    return MAXW'(s);
  endfunction

endpackage

// File: rtl/sdp_minmax.sv
// Signed min/max select of two WIDTH-bit values; ties return d.
module sdp_minmax #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] e_i,
  input  logic             max_i,
  output logic [WIDTH-1:0] z_c_o
);

  logic gt_c;

  always_comb begin
    gt_c  = $signed(d_i) > $signed(e_i);
    z_c_o = d_i;
    if (max_i) begin
      z_c_o = gt_c ? d_i : e_i;
    end else begin
      z_c_o = gt_c ? e_i : d_i;
    end
  end

endmodule

// File: rtl/sdp_pipe.sv
// 3-stage valid/ready signed datapath: z = min/max(a+b, a+c), x = a*c - (a+b).
// Define SDP_SAT_EN to saturate the stage-1 sums instead of wrapping. WIDTH <= 32.
module sdp_pipe
  import sdp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   z,
  output logic [2*WIDTH-1:0] x
);

  localparam int unsigned XW = 2 * WIDTH;

  stage_valid_t     v_q, v_d;
  logic             adv_c;

  logic [WIDTH-1:0] a1_q, a1_d, c1_q, c1_d;
  logic [WIDTH-1:0] d1_q, d1_d, e1_q, e1_d;
  logic             m1_q, m1_d;

  logic [WIDTH-1:0] z2_q, z2_d, d2_q, d2_d;
  logic [XW-1:0]    f2_q, f2_d;

  logic [WIDTH-1:0] z3_q, z3_d;
  logic [XW-1:0]    x3_q, x3_d;

  logic [WIDTH-1:0] sum_ab_c, sum_ac_c, zsel_c;
  logic [XW-1:0]    a_ext_c, c_ext_c, d_ext_c;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv_c     = !v_q.v3 || out_ready;
  assign in_ready  = adv_c;
  assign out_valid = v_q.v3;
  assign z         = z3_q;
  assign x         = x3_q;

`ifdef SDP_SAT_EN
  assign sum_ab_c = WIDTH'(sat_add(MAXW'(a), MAXW'(b), WIDTH));
  assign sum_ac_c = WIDTH'(sat_add(MAXW'(a), MAXW'(c), WIDTH));
`else
  assign sum_ab_c = a + b;
  assign sum_ac_c = a + c;
`endif

  sdp_minmax #(
    .WIDTH (WIDTH)
  ) u_minmax (
    .d_i   (d1_q),
    .e_i   (e1_q),
    .max_i (m1_q),
    .z_c_o (zsel_c)
  );

  assign a_ext_c = XW'(sext2w(MAXW'(a1_q), WIDTH));
  assign c_ext_c = XW'(sext2w(MAXW'(c1_q), WIDTH));
  assign d_ext_c = XW'(sext2w(MAXW'(d2_q), WIDTH));

  // Next-state: hold everything unless the pipe advances.
  always_comb begin
    v_d  = v_q;
    a1_d = a1_q;
    c1_d = c1_q;
    d1_d = d1_q;
    e1_d = e1_q;
    m1_d = m1_q;
    z2_d = z2_q;
    d2_d = d2_q;
    f2_d = f2_q;
    z3_d = z3_q;
    x3_d = x3_q;
    if (adv_c) begin
      v_d.v1 = in_valid;
      v_d.v2 = v_q.v1;
      v_d.v3 = v_q.v2;
      // S1 captures only real inputs so undriven bus values never enter the pipe.
      if (in_valid) begin
        a1_d = a;
        c1_d = c;
        d1_d = sum_ab_c;
        e1_d = sum_ac_c;
        m1_d = mode;
      end
      z2_d = zsel_c;
      d2_d = d1_q;
      f2_d = a_ext_c * c_ext_c;
      z3_d = z2_q;
      x3_d = f2_q - d_ext_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q  <= '0;
      a1_q <= '0;
      c1_q <= '0;
      d1_q <= '0;
      e1_q <= '0;
      m1_q <= 1'b0;
      z2_q <= '0;
      d2_q <= '0;
      f2_q <= '0;
      z3_q <= '0;
      x3_q <= '0;
    end else begin
      v_q  <= v_d;
      a1_q <= a1_d;
      c1_q <= c1_d;
      d1_q <= d1_d;
      e1_q <= e1_d;
      m1_q <= m1_d;
      z2_q <= z2_d;
      d2_q <= d2_d;
      f2_q <= f2_d;
      z3_q <= z3_d;
      x3_q <= x3_d;
    end
  end

endmodule

// File: tb/tb_sdp_pipe.sv
// Directed-vector bench for sdp_pipe (WIDTH=8) with an in-order scoreboard.
module tb_sdp_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned XW = 2 * W;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic          mode;
    logic [W-1:0]  z;
    logic [XW-1:0] x;
  } vec_t;

  typedef struct {
    logic [W-1:0]  z;
    logic [XW-1:0] x;
    int            cyc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  z;
  logic [XW-1:0] x;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  logic lat_chk  = 1'b1;
  exp_t q[$];
  vec_t vt[8];

  sdp_pipe #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .x         (x)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic vec_t mkv(input int a_, input int b_, input int c_,
                               input logic m_, input int z_, input int x_);
    vec_t v;
    v.a = W'(a_); v.b = W'(b_); v.c = W'(c_);
    v.mode = m_;  v.z = W'(z_); v.x = XW'(x_);
    return v;
  endfunction

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Drive one cycle's inputs (call just after a negedge), then score any transfers.
  task automatic drive(input logic iv, input vec_t v, input logic ordy, output logic acc);
    exp_t e;
    in_valid = iv; a = v.a; b = v.b; c = v.c; mode = v.mode; out_ready = ordy;
    #1;
    acc = 1'b0;
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        chk("z", longint'($signed(z)), longint'($signed(e.z)));
        chk("x", longint'($signed(x)), longint'($signed(e.x)));
        if (lat_chk) chk("latency", longint'(cyc - e.cyc), 3);
      end
    end
    if (iv && in_ready && !RST) begin
      q.push_back('{z: v.z, x: v.x, cyc: cyc});
      acc = 1'b1;
    end
  endtask

  initial begin
    logic acc;
    logic ordy;
    int   idx;
    int   stall_left;
    int   nbase;
    logic seen;
    logic bv[8];
    logic ov[8];

    RST = 1'b1; in_valid = 1'b0; mode = 1'b0;
    a = '0; b = '0; c = '0; out_ready = 1'b0;

    vt[0] = mkv(3, 4, 5, 1'b0, 7, 8);
    vt[1] = mkv(3, 4, 5, 1'b1, 8, 8);
    vt[2] = mkv(-2, 1, -3, 1'b0, -5, 7);
`ifdef SDP_SAT_EN
    vt[3] = mkv(100, 100, 1, 1'b0, 101, -27);
    vt[5] = mkv(-128, -128, 127, 1'b1, -1, -16128);
    vt[6] = mkv(127, 1, -1, 1'b0, 126, -254);
`else
    vt[3] = mkv(100, 100, 1, 1'b0, -56, 156);
    vt[5] = mkv(-128, -128, 127, 1'b1, 0, -16256);
    vt[6] = mkv(127, 1, -1, 1'b0, -128, 1);
`endif
    vt[4] = mkv(0, 5, 5, 1'b1, 5, -5);
    vt[7] = mkv(-5, -3, 7, 1'b1, 2, -27);

    // Reset state, with out_ready low so in_ready must come from the empty pipe.
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_z", longint'(z), 0);
      chk("rst_x", longint'(x), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
    end
    RST = 1'b0;

    // Table vectors streamed back to back, full throughput.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge CLK);
      drive(1'b1, vt[i], 1'b1, acc);
      chk("accept", longint'(acc), 1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      drive(1'b0, vt[0], 1'b1, acc);
    end
    chk("table_pending", longint'(q.size()), 0);

    // Backpressure: 10 triples, out_ready low for 5 cycles once out_valid rises.
    lat_chk = 1'b0; idx = 0; seen = 1'b0; stall_left = 0; nbase = n_out;
    for (int k = 0; k < 60 && !(idx == 10 && q.size() == 0); k++) begin
      @(negedge CLK);
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 5;
      end
      ordy = (stall_left == 0);
      drive(idx < 10, vt[idx % 8], ordy, acc);
      if (stall_left > 0) begin
        chk("stall_in_ready", longint'(in_ready), 0);
        chk("stall_out_valid", longint'(out_valid), 1);
        if (q.size() > 0) begin
          chk("stall_z", longint'($signed(z)), longint'($signed(q[0].z)));
          chk("stall_x", longint'($signed(x)), longint'($signed(q[0].x)));
        end
        stall_left--;
      end
      if (acc) idx++;
    end
    chk("bp_results", longint'(n_out - nbase), 10);
    chk("bp_pending", longint'(q.size()), 0);
    lat_chk = 1'b1;

    // Reset with three transactions in flight; none may emerge afterwards.
    nbase = n_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(1'b1, vt[i + 1], 1'b1, acc);
    end
    @(negedge CLK);
    RST = 1'b1;
    drive(1'b0, vt[0], 1'b0, acc);
    chk("inflight_valid", longint'(out_valid), 1);
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_z", longint'(z), 0);
    chk("midrst_x", longint'(x), 0);
    q.delete();
    drive(1'b1, vt[7], 1'b1, acc);
    chk("post_rst_accept", longint'(acc), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      drive(1'b0, vt[0], 1'b1, acc);
    end
    chk("post_rst_results", longint'(n_out - nbase), 1);
    chk("post_rst_pending", longint'(q.size()), 0);

    // Bubbles propagate with a fixed 3-cycle offset.
    bv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      drive(bv[k], vt[k], 1'b1, acc);
      ov[k] = out_valid;
    end
    for (int k = 0; k < 8; k++) begin
      chk("bubble_out_valid", longint'(ov[k]), (k < 3) ? 0 : longint'(bv[k - 3]));
    end
    chk("bubble_pending", longint'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
